// File: rtl/hog_lite_regs.sv
// Xillybus Lite register block for the HOG/SVM accelerator: control, status, IRQ, bias and a result FIFO.
// Optional build macro: HOG_LITE_CYCLE_CNT_EN adds a busy-cycle counter at 0x1C.
module hog_lite_regs (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic        user_wren,
  input  logic [3:0]  user_wstrb,
  input  logic        user_rden,
  input  logic [31:0] user_addr,
  input  logic [31:0] user_wr_data,
  output logic [31:0] user_rd_data,
  output logic        user_irq,
  output logic        acc_start,
  output logic        acc_enable,
  output logic [31:0] acc_bias,
  input  logic        acc_busy,
  input  logic        acc_done,
  input  logic        det_valid,
  input  logic [31:0] det_data
);

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned PTR_W      = 4;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned IDX_W      = 5;
  localparam int unsigned NUM_BYTES  = 4;

  localparam logic [IDX_W-1:0] REG_CTRL      = IDX_W'(0);
  localparam logic [IDX_W-1:0] REG_STATUS    = IDX_W'(1);
  localparam logic [IDX_W-1:0] REG_IRQ_EN    = IDX_W'(2);
  localparam logic [IDX_W-1:0] REG_IRQ_STAT  = IDX_W'(3);
  localparam logic [IDX_W-1:0] REG_BIAS      = IDX_W'(4);
  localparam logic [IDX_W-1:0] REG_FRAME_CNT = IDX_W'(5);
  localparam logic [IDX_W-1:0] REG_RESULT    = IDX_W'(6);
  localparam logic [IDX_W-1:0] REG_CYCLE_CNT = IDX_W'(7);
  localparam logic [IDX_W-1:0] REG_ID        = IDX_W'(8);

  localparam logic [DATA_W-1:0] ID_VALUE = 32'h484F_4731;

  logic [IDX_W-1:0]  reg_idx;
  logic              wr_ctrl;
  logic              wr_irq_en;
  logic              wr_irq_stat;
  logic              wr_bias;
  logic              soft_clr;
  logic              rd_result;

  logic [1:0]        irq_en;
  logic [1:0]        irq_stat;
  logic [1:0]        irq_stat_nxt;
  logic [DATA_W-1:0] frame_cnt;
  logic [DATA_W-1:0] cycle_cnt;
  logic [DATA_W-1:0] rd_mux;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_push;
  logic              fifo_pop;
  logic              ovf_set;

  logic              unused_addr_bits;

  assign unused_addr_bits = ^{user_addr[31:7], user_addr[1:0]};

  // Address decode and access strobes
  assign reg_idx     = user_addr[6:2];
  assign wr_ctrl     = user_wren && (reg_idx == REG_CTRL) && user_wstrb[0];
  assign wr_irq_en   = user_wren && (reg_idx == REG_IRQ_EN) && user_wstrb[0];
  assign wr_irq_stat = user_wren && (reg_idx == REG_IRQ_STAT) && user_wstrb[0];
  assign wr_bias     = user_wren && (reg_idx == REG_BIAS);
  assign soft_clr    = wr_ctrl && user_wr_data[1];
  assign rd_result   = user_rden && (reg_idx == REG_RESULT);

  // FIFO flow control: a pop frees the slot a same-cycle push needs when full
  assign fifo_empty = (fifo_count == CNT_W'(0));
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_pop   = rd_result && !fifo_empty;
  assign fifo_push  = det_valid && (!fifo_full || fifo_pop);
  assign ovf_set    = det_valid && fifo_full && !fifo_pop;

  always_ff @(posedge user_clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr] <= det_data;
    end
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst_n || soft_clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Control, enable and bias registers
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      acc_start  <= 1'b0;
      acc_enable <= 1'b0;
      irq_en     <= '0;
      acc_bias   <= '0;
    end else begin
      acc_start <= wr_ctrl && user_wr_data[0];
      if (wr_ctrl) begin
        acc_enable <= user_wr_data[2];
      end
      if (wr_irq_en) begin
        irq_en <= user_wr_data[1:0];
      end
      if (wr_bias) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (user_wstrb[b]) begin
            acc_bias[8*b +: 8] <= user_wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // W1C clear first, then hardware set so a same-cycle set wins
  always_comb begin
    irq_stat_nxt = irq_stat;
    if (wr_irq_stat) begin
      irq_stat_nxt = irq_stat_nxt & ~user_wr_data[1:0];
    end
    irq_stat_nxt = irq_stat_nxt | {ovf_set, acc_done};
    if (soft_clr) begin
      irq_stat_nxt = '0;
    end
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      irq_stat  <= '0;
      frame_cnt <= '0;
      user_irq  <= 1'b0;
    end else begin
      irq_stat <= irq_stat_nxt;
      user_irq <= |(irq_stat & irq_en);
      if (soft_clr) begin
        frame_cnt <= '0;
      end else if (acc_done) begin
        frame_cnt <= frame_cnt + DATA_W'(1);
      end
    end
  end

`ifdef HOG_LITE_CYCLE_CNT_EN
  always_ff @(posedge user_clk) begin
    if (!user_rst_n || soft_clr) begin
      cycle_cnt <= '0;
    end else if (acc_busy) begin
      cycle_cnt <= cycle_cnt + DATA_W'(1);
    end
  end
`else
  assign cycle_cnt = '0;
`endif

  // Read mux; start and soft_clr are pulses and read back as 0
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      REG_CTRL:      rd_mux = {29'd0, acc_enable, 2'b00};
      REG_STATUS:    rd_mux = {19'd0, fifo_count, 5'd0, fifo_full, fifo_empty, acc_busy};
      REG_IRQ_EN:    rd_mux = {30'd0, irq_en};
      REG_IRQ_STAT:  rd_mux = {30'd0, irq_stat};
      REG_BIAS:      rd_mux = acc_bias;
      REG_FRAME_CNT: rd_mux = frame_cnt;
      REG_RESULT:    rd_mux = fifo_empty ? '0 : fifo_mem[rd_ptr];
      REG_CYCLE_CNT: rd_mux = cycle_cnt;
      REG_ID:        rd_mux = ID_VALUE;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      user_rd_data <= '0;
    end else if (user_rden) begin
      user_rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_hog_lite_regs.sv
// Directed testbench for hog_lite_regs: register access, FIFO, IRQ and reset behaviour.
module tb_hog_lite_regs;

  logic        user_clk;
  logic        user_rst_n;
  logic        user_wren;
  logic [3:0]  user_wstrb;
  logic        user_rden;
  logic [31:0] user_addr;
  logic [31:0] user_wr_data;
  logic [31:0] user_rd_data;
  logic        user_irq;
  logic        acc_start;
  logic        acc_enable;
  logic [31:0] acc_bias;
  logic        acc_busy;
  logic        acc_done;
  logic        det_valid;
  logic [31:0] det_data;

  int checks;
  int errors;
  logic [31:0] rdv;
  logic [31:0] exp_cycles;

  hog_lite_regs dut (
    .user_clk     (user_clk),
    .user_rst_n   (user_rst_n),
    .user_wren    (user_wren),
    .user_wstrb   (user_wstrb),
    .user_rden    (user_rden),
    .user_addr    (user_addr),
    .user_wr_data (user_wr_data),
    .user_rd_data (user_rd_data),
    .user_irq     (user_irq),
    .acc_start    (acc_start),
    .acc_enable   (acc_enable),
    .acc_bias     (acc_bias),
    .acc_busy     (acc_busy),
    .acc_done     (acc_done),
    .det_valid    (det_valid),
    .det_data     (det_data)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(negedge user_clk);
    user_wren    = 1'b1;
    user_addr    = addr;
    user_wr_data = data;
    user_wstrb   = strb;
    @(negedge user_clk);
    user_wren  = 1'b0;
    user_wstrb = 4'h0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    @(negedge user_clk);
    user_rden = 1'b1;
    user_addr = addr;
    @(negedge user_clk);
    user_rden = 1'b0;
    data = user_rd_data;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    user_rst_n   = 1'b0;
    user_wren    = 1'b0;
    user_wstrb   = 4'h0;
    user_rden    = 1'b0;
    user_addr    = 32'h0;
    user_wr_data = 32'h0;
    acc_busy     = 1'b0;
    acc_done     = 1'b0;
    det_valid    = 1'b0;
    det_data     = 32'h0;
`ifdef HOG_LITE_CYCLE_CNT_EN
    exp_cycles = 32'd100;
`else
    exp_cycles = 32'd0;
`endif

    // Reset values
    repeat (3) @(negedge user_clk);
    check("rst_rd_data", user_rd_data, 32'h0);
    check("rst_irq", {31'd0, user_irq}, 32'h0);
    check("rst_start", {31'd0, acc_start}, 32'h0);
    check("rst_enable", {31'd0, acc_enable}, 32'h0);
    check("rst_bias", acc_bias, 32'h0);
    user_rst_n = 1'b1;

    // ID, STATUS, unmapped
    rd(32'h20, rdv); check("id", rdv, 32'h484F4731);
    rd(32'h04, rdv); check("status_reset", rdv, 32'h00000002);
    rd(32'h24, rdv); check("unmapped_rd", rdv, 32'h0);
    wr(32'h28, 32'hFFFFFFFF, 4'hF);
    rd(32'h0C, rdv); check("unmapped_wr_irqstat", rdv, 32'h0);

    // BIAS byte strobes
    wr(32'h10, 32'hDEADBEEF, 4'hF);
    wr(32'h10, 32'h00000011, 4'h1);
    check("acc_bias", acc_bias, 32'hDEADBE11);
    rd(32'h10, rdv); check("bias_rd", rdv, 32'hDEADBE11);

    // CTRL start pulse and enable
    wr(32'h00, 32'h5, 4'h1);
    check("start_pulse", {31'd0, acc_start}, 32'h1);
    check("enable", {31'd0, acc_enable}, 32'h1);
    @(negedge user_clk);
    check("start_drop", {31'd0, acc_start}, 32'h0);
    rd(32'h00, rdv); check("ctrl_rd1", rdv, 32'h4);
    rd(32'h00, rdv); check("ctrl_rd2", rdv, 32'h4);

    // FIFO overflow with IRQ_EN=0x2
    wr(32'h08, 32'h2, 4'h1);
    rd(32'h08, rdv); check("irq_en_rd", rdv, 32'h2);
    for (int i = 0; i < 17; i++) begin
      @(negedge user_clk);
      det_valid = 1'b1;
      det_data  = 32'h1000 + i;
    end
    @(negedge user_clk);
    det_valid = 1'b0;
    rd(32'h04, rdv); check("status_full", rdv, 32'h00001004);
    rd(32'h0C, rdv); check("irq_stat_ovf", rdv, 32'h2);
    check("irq_ovf", {31'd0, user_irq}, 32'h1);
    for (int i = 0; i < 16; i++) begin
      rd(32'h18, rdv);
      check($sformatf("result_%0d", i), rdv, 32'h1000 + i);
    end
    rd(32'h18, rdv); check("result_empty", rdv, 32'h0);
    rd(32'h04, rdv); check("status_empty", rdv, 32'h2);
    wr(32'h0C, 32'h2, 4'h1);
    rd(32'h0C, rdv); check("irq_stat_w1c", rdv, 32'h0);
    check("irq_cleared", {31'd0, user_irq}, 32'h0);

    // acc_done collides with W1C of done: set wins
    @(negedge user_clk);
    user_wren    = 1'b1;
    user_addr    = 32'h0C;
    user_wr_data = 32'h1;
    user_wstrb   = 4'h1;
    acc_done     = 1'b1;
    @(negedge user_clk);
    user_wren  = 1'b0;
    user_wstrb = 4'h0;
    acc_done   = 1'b0;
    rd(32'h0C, rdv); check("done_set_wins", rdv, 32'h1);
    rd(32'h14, rdv); check("frame_cnt", rdv, 32'h1);
    wr(32'h0C, 32'h1, 4'h1);
    rd(32'h0C, rdv); check("done_w1c", rdv, 32'h0);

    // Push and pop in the same cycle while full
    for (int i = 0; i < 16; i++) begin
      @(negedge user_clk);
      det_valid = 1'b1;
      det_data  = 32'h2000 + i;
    end
    @(negedge user_clk);
    det_valid = 1'b0;
    rd(32'h04, rdv); check("status_full16", rdv, 32'h00001004);
    @(negedge user_clk);
    user_rden = 1'b1;
    user_addr = 32'h18;
    det_valid = 1'b1;
    det_data  = 32'h3000;
    @(negedge user_clk);
    user_rden = 1'b0;
    det_valid = 1'b0;
    check("full_pushpop_rd", user_rd_data, 32'h2000);
    rd(32'h04, rdv); check("full_pushpop_cnt", rdv, 32'h00001004);
    rd(32'h0C, rdv); check("full_pushpop_noovf", rdv, 32'h0);

    // Soft clear keeps enable, IRQ_EN, BIAS
    wr(32'h00, 32'h6, 4'h1);
    check("softclr_no_start", {31'd0, acc_start}, 32'h0);
    rd(32'h04, rdv); check("softclr_status", rdv, 32'h2);
    rd(32'h14, rdv); check("softclr_frame", rdv, 32'h0);
    rd(32'h10, rdv); check("softclr_bias", rdv, 32'hDEADBE11);
    rd(32'h08, rdv); check("softclr_irq_en", rdv, 32'h2);
    rd(32'h00, rdv); check("softclr_ctrl", rdv, 32'h4);

    // Busy cycle counter
    @(negedge user_clk);
    acc_busy = 1'b1;
    repeat (100) @(negedge user_clk);
    acc_busy = 1'b0;
    rd(32'h1C, rdv); check("cycle_cnt", rdv, exp_cycles);

    // Reset mid-operation discards FIFO and pending start
    for (int i = 0; i < 3; i++) begin
      @(negedge user_clk);
      det_valid = 1'b1;
      det_data  = 32'h4000 + i;
    end
    @(negedge user_clk);
    det_valid    = 1'b0;
    user_wren    = 1'b1;
    user_addr    = 32'h00;
    user_wr_data = 32'h1;
    user_wstrb   = 4'h1;
    user_rst_n   = 1'b0;
    @(negedge user_clk);
    user_wren  = 1'b0;
    user_wstrb = 4'h0;
    check("midrst_start", {31'd0, acc_start}, 32'h0);
    check("midrst_enable", {31'd0, acc_enable}, 32'h0);
    check("midrst_bias", acc_bias, 32'h0);
    @(negedge user_clk);
    user_rst_n = 1'b1;
    rd(32'h04, rdv); check("midrst_status", rdv, 32'h2);
    rd(32'h18, rdv); check("midrst_result", rdv, 32'h0);
    rd(32'h1C, rdv); check("midrst_cycle", rdv, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hog_lite_regs.md
HOG_LITE_REGS -- requirements
Module: hog_lite_regs

Interface
REQ-001 The block SHALL have one clock `user_clk` (input, 1): the Xillybus Lite user clock; all logic rises on this edge.
REQ-002 The block SHALL have reset `user_rst_n` (input, 1): synchronous, active-low.
REQ-003 The block SHALL have `user_wren` (input, 1): write strobe, single cycle.
REQ-004 The block SHALL have `user_wstrb` (input, 4): byte enables for a write.
REQ-005 The block SHALL have `user_rden` (input, 1): read strobe, single cycle.
REQ-006 The block SHALL have `user_addr` (input, 32): byte address; `user_addr[6:2]` selects the register; other bits are ignored.
REQ-007 The block SHALL have `user_wr_data` (input, 32): write data.
REQ-008 The block SHALL have `user_rd_data` (output, 32): read data.
REQ-009 The block SHALL have `user_irq` (output, 1): level interrupt to the host.
REQ-010 The block SHALL have `acc_start` (output, 1): one-cycle start pulse to the HOG/SVM core.
REQ-011 The block SHALL have `acc_enable` (output, 1): level enable to the core.
REQ-012 The block SHALL have `acc_bias` (output, 32): SVM bias value.
REQ-013 The block SHALL have `acc_busy` (input, 1): core busy.
REQ-014 The block SHALL have `acc_done` (input, 1): one-cycle frame-complete pulse.
REQ-015 The block SHALL have `det_valid` (input, 1) and `det_data` (input, 32): detection result push with no back-pressure.

Function
REQ-016 The register map SHALL be:
- 0x00 CTRL: bit0 start (write-1 pulse); bit1 soft_clr (write-1 pulse); bit2 enable (RW).
- 0x04 STATUS (RO): bit0 busy, bit1 fifo_empty, bit2 fifo_full, [12:8] fifo_count.
- 0x08 IRQ_EN (RW): bits [1:0].
- 0x0C IRQ_STAT (W1C): bit0 done, bit1 overflow.
- 0x10 BIAS (RW): 32 bits.
- 0x14 FRAME_CNT (RO).
- 0x18 RESULT (RO, pop).
- 0x1C CYCLE_CNT.
- 0x20 ID (RO) = 0x484F4731.
REQ-017 Unmapped reads SHALL return 0; unmapped writes SHALL be ignored.
REQ-018 `user_rd_data` SHALL be registered and valid on the cycle after `user_rden`; it SHALL hold its value until the next read.
REQ-019 Writes SHALL honour `user_wstrb` per byte for BIAS and IRQ_EN. CTRL and IRQ_STAT SHALL act only when `user_wstrb[0]` is set.
REQ-020 A CTRL write with bit0=1 SHALL assert `acc_start` for exactly the next cycle, regardless of `acc_busy`.
REQ-021 A CTRL write with bit1=1 SHALL, on the next cycle, clear the FIFO, IRQ_STAT, FRAME_CNT and CYCLE_CNT; it SHALL leave CTRL.enable, IRQ_EN and BIAS unchanged.
REQ-022 Result FIFO: depth 16, 32-bit entries, fifo_count 0..16, pointers 4-bit wrapping.
REQ-023 `det_valid` while not full SHALL push `det_data`.
REQ-024 `det_valid` while full without a pop SHALL drop the data and set IRQ_STAT.overflow.
REQ-025 A push and a pop in the same cycle while full SHALL both succeed; fifo_count stays 16 and overflow is not set.
REQ-026 A RESULT read SHALL return the head entry and pop it. A RESULT read while empty SHALL return 0 and change no state.
REQ-027 `acc_done` SHALL set IRQ_STAT.done and increment FRAME_CNT modulo 2^32.
REQ-028 If a hardware set and a W1C clear hit the same IRQ_STAT bit in the same cycle, the set SHALL win.
REQ-029 `user_irq` SHALL equal the registered value of |(IRQ_STAT & IRQ_EN[1:0]), so it follows a cause by one cycle.

Reset
REQ-030 While `user_rst_n`=0 at a clock edge, all of the following SHALL be 0: CTRL, IRQ_EN, IRQ_STAT, BIAS, FRAME_CNT, CYCLE_CNT, FIFO pointers and count, `user_rd_data`, `user_irq`, `acc_start`, `acc_enable`.
REQ-031 A reset asserted mid-operation SHALL discard FIFO contents and any pending start pulse. The first access after release SHALL see the reset values.

Configuration
REQ-032 With `HOG_LITE_CYCLE_CNT_EN` defined, CYCLE_CNT SHALL increment every cycle in which `acc_busy`=1, wrap modulo 2^32, and be read-only.
REQ-033 With `HOG_LITE_CYCLE_CNT_EN` undefined, no counter logic SHALL be built and 0x1C SHALL read 0.

Verification
REQ-034 Reset, then read 0x20 -> 0x484F4731 one cycle after rden; read 0x04 -> 0x00000002.
REQ-035 Write BIAS 0xDEADBEEF with wstrb=0xF, then 0x00000011 with wstrb=0x1 -> `acc_bias`=0xDEADBE11, read back identically.
REQ-036 Write CTRL=0x5 -> `acc_start` high exactly 1 cycle, `acc_enable`=1; a second read of CTRL -> 0x4.
REQ-037 Push 17 detections with IRQ_EN=0x2 -> STATUS[12:8]=16, IRQ_STAT=0x2, `user_irq`=1. Then 16 RESULT reads -> first 16 values in order. A 17th read -> 0.
REQ-038 Pulse `acc_done` in the same cycle as a W1C of IRQ_STAT=0x1 -> IRQ_STAT.done stays 1 and FRAME_CNT=1.
REQ-039 Hold `acc_busy` for 100 cycles, then read 0x1C -> 100 when the macro is defined, 0 when it is not.
